// File: rtl/npc_pkg.sv
// Shared IFU definitions: fetch FSM states, address width and reset PC.
// The optional fetch counter is enabled by macro IFU_PERF_EN (see ifu.sv).
package npc_pkg;

  localparam int XLEN = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_e;

endpackage

// File: rtl/ifu_ibuf.sv
// IFU instruction buffer: holds inst/pc for decode and owns the
// inst_valid/inst_ready handshake.
module ifu_ibuf #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(npc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     data,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inst_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            fire
);

  assign fire = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      pc         <= RESET_PC;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst       <= data;
      pc         <= load_pc;
    end else if (fire) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with redirects.
// Define IFU_PERF_EN to add the perf_fetch_cnt handshake counter.
module ifu #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(npc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            inst_ready,
`ifdef IFU_PERF_EN
  output logic [63:0]     perf_fetch_cnt,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  import npc_pkg::*;

  ifu_state_e      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic            drop;
  logic            load;
  logic            flush;
  logic            fire;

  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_addr = fetch_pc;
  assign load     = (state == WAIT) & resp_valid
                  & ~drop & ~redirect_valid;
  assign flush    = (state == HOLD) & redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop      <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
          if (redirect_valid) fetch_pc <= target;
        end
        REQ: begin
          if (redirect_valid) fetch_pc <= target;
          if (req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
            drop      <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) fetch_pc <= target;
          if (resp_valid) begin
            drop <= 1'b0;
            // a same-cycle redirect kills the arriving response too
            if (drop || redirect_valid) begin
              state     <= REQ;
              req_valid <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || fire) begin
            state     <= REQ;
            req_valid <= 1'b1;
            fetch_pc  <= redirect_valid ? target
                                        : fetch_pc + XLEN'(4);
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  ifu_ibuf #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .data      (resp_data),
    .load_pc   (fetch_pc),
    .inst_ready(inst_ready),
    .inst_valid(inst_valid),
    .inst      (inst),
    .pc        (pc),
    .fire      (fire)
  );

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    perf_fetch_cnt <= '0;
    else if (fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// Randomized IFU bench against a transaction-level fetch model.
// Covers full-speed fetch, backpressure, redirects, PC wrap and resets.
module tb_ifu;

  localparam int XLEN = 64;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
`endif

  always #5 clk = ~clk;

  ifu #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc            (pc),
    .inst_ready    (inst_ready),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: what the fetcher is doing, not how it is encoded.
  bit          m_start;
  bit          m_req;
  bit          m_out;
  bit          m_disc;
  bit          m_hold;
  logic [63:0] m_addr;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_cnt;

  task automatic model_reset();
    m_start = 1'b1;
    m_req   = 1'b0;
    m_out   = 1'b0;
    m_disc  = 1'b0;
    m_hold  = 1'b0;
    m_addr  = RST_PC;
    m_pc    = RST_PC;
    m_inst  = '0;
    m_cnt   = '0;
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    tgt = redirect_pc & ~64'h3;
    if (m_start) begin
      m_start = 1'b0;
      m_req   = 1'b1;
      if (redirect_valid) m_addr = tgt;
    end else if (m_req) begin
      if (redirect_valid) m_addr = tgt;
      if (req_ready) begin
        m_req  = 1'b0;
        m_out  = 1'b1;
        m_disc = redirect_valid;
      end
    end else if (m_out) begin
      if (redirect_valid) m_addr = tgt;
      if (resp_valid) begin
        m_out = 1'b0;
        if (m_disc || redirect_valid) begin
          m_req = 1'b1;
        end else begin
          m_hold = 1'b1;
          m_inst = resp_data;
          m_pc   = m_addr;
        end
        m_disc = 1'b0;
      end else if (redirect_valid) begin
        m_disc = 1'b1;
      end
    end else if (m_hold) begin
      if (inst_ready) m_cnt = m_cnt + 64'd1;
      if (redirect_valid || inst_ready) begin
        m_hold = 1'b0;
        m_req  = 1'b1;
        m_addr = redirect_valid ? tgt : m_addr + 64'd4;
      end
    end
  endtask

  task automatic check_outputs();
    check("req_valid", req_valid, m_req);
    if (m_req) check("req_addr", req_addr, m_addr);
    check("inst_valid", inst_valid, m_hold);
    if (m_hold) begin
      check("inst", inst, m_inst);
      check("pc", pc, m_pc);
    end
`ifdef IFU_PERF_EN
    check("perf_cnt", perf_fetch_cnt, m_cnt);
`endif
  endtask

  task automatic check_reset();
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_addr", req_addr, RST_PC);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 64'd0);
    check("rst_pc", pc, RST_PC);
  endtask

  task automatic drive(input bit directed);
    resp_data = $urandom;
    if (directed) begin
      req_ready      = 1'b1;
      resp_valid     = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
    end else begin
      req_ready      = ($urandom % 10) < 7;
      resp_valid     = ($urandom % 2) == 0;
      inst_ready     = ($urandom % 10) < 6;
      redirect_valid = ($urandom % 100) < 6;
      case ($urandom % 4)
        0: redirect_pc = RST_PC + 64'($urandom % 256);
        1: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0
                       | 64'($urandom % 16);
        2: redirect_pc = {$urandom, $urandom};
        default: redirect_pc = 64'h8000_0100
                             + 64'($urandom % 8);
      endcase
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_reset();
    #3 rst_n = 1'b1;
    @(posedge clk);
    model_step();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (cyc > 40 && ($urandom % 300) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        drive(1'b0);
        #2 rst_n = 1'b1;
      end else begin
        check_outputs();
        drive(cyc < 30);
        if (cyc == 12) begin
          redirect_valid = 1'b1;
          redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        end
      end
      @(posedge clk);
      model_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
